// File: rtl/serial_pattern_generator.sv
// rtl/serial_pattern_generator.sv - programmable MSB-first serial bit pattern transmitter
module serial_pattern_generator #(
  parameter int MAXLEN = 16,
  parameter int LENW   = 5,
  parameter int REPW   = 4,
  parameter int GAPW   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [MAXLEN-1:0] pattern,
  input  logic [LENW-1:0]   length,
  input  logic [REPW-1:0]   repeat_cnt,
  input  logic [GAPW-1:0]   gap,
  input  logic              idle_level,
  input  logic              abort,
  output logic              x,
  output logic              x_valid,
  output logic              frame_start,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  localparam logic [LENW-1:0] MAXLEN_L = LENW'(MAXLEN);

  state_t            state_q, state_d;
  logic [MAXLEN-1:0] pat_q, pat_d;     // latched pattern, left-aligned so the first bit is the MSB
  logic [MAXLEN-1:0] sh_q, sh_d;       // working copy shifted out during a frame
  logic [LENW-1:0]   len_q, len_d;
  logic [LENW-1:0]   idx_q, idx_d;     // index of the bit currently on x, counts down to 0
  logic [REPW-1:0]   frm_q, frm_d;     // frames still to send after the current one
  logic [GAPW-1:0]   gap_q, gap_d;
  logic [GAPW-1:0]   gcnt_q, gcnt_d;   // idle cycles left in the current gap, including this one
  logic              idle_q, idle_d;
  logic              x_d, xv_d, fs_d, done_d;

  logic [LENW-1:0]   len_clamp;
  logic [MAXLEN-1:0] pat_align;

  // Clamp the requested length and align the pattern so bit [L-1] lands in the MSB
  assign len_clamp   = (length > MAXLEN_L) ? MAXLEN_L : length;
  assign pat_align   = pattern << (MAXLEN_L - len_clamp);
  assign start_ready = (state_q == IDLE);

  // Next-state and registered-output logic; abort overrides everything but reset
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idle_d  = idle_q;
    x_d     = x;
    xv_d    = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;

    if (abort) begin
      state_d = IDLE;
      x_d     = (state_q == IDLE) ? idle_level : idle_q;
    end else begin
      case (state_q)
        IDLE: begin
          x_d = idle_level;
          if (start_valid) begin
            pat_d  = pat_align;
            len_d  = len_clamp;
            frm_d  = repeat_cnt;
            gap_d  = gap;
            idle_d = idle_level;
            if (len_clamp == '0) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = SHIFT;
              x_d     = pat_align[MAXLEN-1];
              xv_d    = 1'b1;
              fs_d    = 1'b1;
              sh_d    = pat_align << 1;
              idx_d   = len_clamp - LENW'(1);
            end
          end
        end

        SHIFT: begin
          if (idx_q != '0) begin
            x_d   = sh_q[MAXLEN-1];
            xv_d  = 1'b1;
            sh_d  = sh_q << 1;
            idx_d = idx_q - LENW'(1);
          end else if (frm_q != '0) begin
            frm_d = frm_q - REPW'(1);
            if (gap_q != '0) begin
              state_d = GAP;
              gcnt_d  = gap_q;
              x_d     = idle_q;
            end else begin
              x_d   = pat_q[MAXLEN-1];
              xv_d  = 1'b1;
              fs_d  = 1'b1;
              sh_d  = pat_q << 1;
              idx_d = len_q - LENW'(1);
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            x_d     = idle_q;
          end
        end

        GAP: begin
          x_d = idle_q;
          if (gcnt_q == GAPW'(1)) begin
            state_d = SHIFT;
            x_d     = pat_q[MAXLEN-1];
            xv_d    = 1'b1;
            fs_d    = 1'b1;
            sh_d    = pat_q << 1;
            idx_d   = len_q - LENW'(1);
          end else begin
            gcnt_d = gcnt_q - GAPW'(1);
          end
        end

        DONE: begin
          state_d = IDLE;
          x_d     = idle_q;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, job latches and registered outputs; asynchronous clear on resetn low
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      sh_q        <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      frm_q       <= '0;
      gap_q       <= '0;
      gcnt_q      <= '0;
      idle_q      <= 1'b0;
      x           <= 1'b0;
      x_valid     <= 1'b0;
      frame_start <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      sh_q        <= sh_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      frm_q       <= frm_d;
      gap_q       <= gap_d;
      gcnt_q      <= gcnt_d;
      idle_q      <= idle_d;
      x           <= x_d;
      x_valid     <= xv_d;
      frame_start <= fs_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_generator.sv
// tb/tb_serial_pattern_generator.sv - directed self-checking bench for serial_pattern_generator
module tb_serial_pattern_generator;

  logic        clk;
  logic        resetn;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] pattern;
  logic [4:0]  length;
  logic [3:0]  repeat_cnt;
  logic [3:0]  gap;
  logic        idle_level;
  logic        abort;
  logic        x;
  logic        x_valid;
  logic        frame_start;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  serial_pattern_generator #(
    .MAXLEN(16), .LENW(5), .REPW(4), .GAPW(4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .pattern    (pattern),
    .length     (length),
    .repeat_cnt (repeat_cnt),
    .gap        (gap),
    .idle_level (idle_level),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .frame_start(frame_start),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called while clk is low; the job is accepted at the next rising edge
  task automatic start_job(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r,
                           input logic [3:0] g, input logic il);
    pattern     = p;
    length      = l;
    repeat_cnt  = r;
    gap         = g;
    idle_level  = il;
    start_valid = 1'b1;
    chk("start_ready before accept", start_ready, 1'b1);
    @(posedge clk);
    #1 start_valid = 1'b0;
  endtask

  // Cycle +k after acceptance is compared against bit [n-k] of each expectation vector
  task automatic expect_seq(input string tag, input int n, input logic [63:0] ex,
                            input logic [63:0] ev, input logic [63:0] ef,
                            input logic [63:0] ed, input logic [63:0] er);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk($sformatf("%s x@+%0d", tag, k), x, ex[n-k]);
      chk($sformatf("%s x_valid@+%0d", tag, k), x_valid, ev[n-k]);
      chk($sformatf("%s frame_start@+%0d", tag, k), frame_start, ef[n-k]);
      chk($sformatf("%s done@+%0d", tag, k), done, ed[n-k]);
      chk($sformatf("%s start_ready@+%0d", tag, k), start_ready, er[n-k]);
    end
  endtask

  initial begin
    int nbits;
    int done_at;

    resetn      = 1'b0;
    start_valid = 1'b0;
    pattern     = '0;
    length      = '0;
    repeat_cnt  = '0;
    gap         = '0;
    idle_level  = 1'b0;
    abort       = 1'b0;

    #12;
    chk("reset x", x, 1'b0);
    chk("reset x_valid", x_valid, 1'b0);
    chk("reset frame_start", frame_start, 1'b0);
    chk("reset done", done, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    #1 chk("start_ready after release", start_ready, 1'b1);
    @(negedge clk);

    // Basic frame: 1,0,1 then done at +4, ready at +5
    start_job(16'h0005, 5'd3, 4'd0, 4'd0, 1'b0);
    expect_seq("basic", 5, 5'b10100, 5'b11100, 5'b10000, 5'b00010, 5'b00001);

    // Back-to-back repeats without gap
    start_job(16'h0001, 5'd3, 4'd2, 4'd0, 1'b0);
    expect_seq("repeat", 11, 11'b00100100100, 11'b11111111100, 11'b10010010000,
               11'b00000000010, 11'b00000000001);

    // Gap insertion with idle level 1
    start_job(16'h0002, 5'd2, 4'd1, 4'd2, 1'b1);
    expect_seq("gap", 8, 8'b10111011, 8'b11001100, 8'b10001000, 8'b00000010, 8'b00000001);

    // Zero length: straight to DONE
    start_job(16'hFFFF, 5'd0, 4'd3, 4'd1, 1'b0);
    expect_seq("len0", 2, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);

    // Length above MAXLEN is clamped to 16 bits starting at pattern[15]
    start_job(16'hA5C3, 5'd20, 4'd0, 4'd0, 1'b0);
    expect_seq("len20", 18, {16'hA5C3, 2'b00}, {16'hFFFF, 2'b00}, 64'h20000, 64'h2, 64'h1);

    // Maximum repeat and gap: 16 one-bit frames, done at 16+15*15+1 = 242
    start_job(16'h0001, 5'd1, 4'd15, 4'd15, 1'b0);
    nbits   = 0;
    done_at = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (x_valid) nbits++;
      if (done) begin
        done_at = k;
        break;
      end
    end
    chk("maxrep bit count", nbits, 16);
    chk("maxrep done cycle", done_at, 242);
    @(negedge clk);
    chk("maxrep start_ready", start_ready, 1'b1);

    // Abort during the 2nd bit of a 5-bit frame
    start_job(16'h0016, 5'd5, 4'd0, 4'd0, 1'b1);
    expect_seq("abort pre", 2, 2'b10, 2'b11, 2'b10, 2'b00, 2'b00);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort x", x, 1'b1);
    chk("abort x_valid", x_valid, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort start_ready", start_ready, 1'b1);
    start_job(16'h0005, 5'd3, 4'd0, 4'd0, 1'b0);
    expect_seq("after abort", 5, 5'b10100, 5'b11100, 5'b10000, 5'b00010, 5'b00001);

    // Abort in IDLE blocks acceptance
    start_valid = 1'b1;
    abort       = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    abort       = 1'b0;
    @(negedge clk);
    chk("idle abort start_ready", start_ready, 1'b1);
    chk("idle abort x_valid", x_valid, 1'b0);
    @(negedge clk);
    chk("idle abort x_valid later", x_valid, 1'b0);

    // Reset during GAP drops outputs without a clock edge
    start_job(16'h0002, 5'd2, 4'd1, 4'd3, 1'b1);
    expect_seq("rst pre", 3, 3'b101, 3'b110, 3'b100, 3'b000, 3'b000);
    #2 resetn = 1'b0;
    #1;
    chk("midrst x", x, 1'b0);
    chk("midrst x_valid", x_valid, 1'b0);
    chk("midrst frame_start", frame_start, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst start_ready", start_ready, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post rst start_ready", start_ready, 1'b1);
    chk("post rst x_valid", x_valid, 1'b0);
    chk("post rst done", done, 1'b0);
    start_job(16'h0005, 5'd3, 4'd0, 4'd0, 1'b0);
    expect_seq("post rst job", 5, 5'b10100, 5'b11100, 5'b10000, 5'b00010, 5'b00001);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
